// File: rtl/led_activity_stretcher.sv
// Stretches single-cycle activity strobes into visible LED blinks with a minimum
// ON time and OFF gap counted in 1 ms beats. Define LED_ACT_PENDING_EN to queue events seen mid-blink.
module led_activity_stretcher #(
  parameter int ON_MS  = 50,
  parameter int OFF_MS = 50,
  parameter int CNT_W  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_1ms_i,
  input  logic event_i,
  input  logic enable_i,
  output logic led_o,
  output logic busy_o
);

  // state  | meaning
  // S_IDLE | waiting for an event, LED off
  // S_ON   | LED lit, counting ON_MS beats
  // S_OFF  | LED dark, enforcing OFF_MS beat gap
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_MS);
  localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_MS);

  if (ON_MS < 1 || ON_MS > 2**CNT_W - 1) begin : g_bad_on_ms
    $error("led_activity_stretcher: ON_MS out of range for CNT_W");
  end
  if (OFF_MS < 1 || OFF_MS > 2**CNT_W - 1) begin : g_bad_off_ms
    $error("led_activity_stretcher: OFF_MS out of range for CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_d, busy_d;
  logic             expire;
  logic             take_pending;

  assign expire = beat_1ms_i && (cnt_q == CNT_W'(1));

`ifdef LED_ACT_PENDING_EN
  logic pending_q, pending_d;

  // An event arriving in the very cycle the gap expires still counts.
  assign take_pending = pending_q | event_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end
`else
  assign take_pending = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_o   <= led_d;
      busy_o  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef LED_ACT_PENDING_EN
    pending_d = pending_q;
`endif
    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
`ifdef LED_ACT_PENDING_EN
      pending_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (event_i) begin
            state_d = S_ON;
            cnt_d   = ON_CNT;
          end
        end
        S_ON: begin
`ifdef LED_ACT_PENDING_EN
          pending_d = pending_q | event_i;
`endif
          if (expire) begin
            state_d = S_OFF;
            cnt_d   = OFF_CNT;
          end else if (beat_1ms_i && cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_OFF: begin
`ifdef LED_ACT_PENDING_EN
          pending_d = pending_q | event_i;
`endif
          if (expire) begin
`ifdef LED_ACT_PENDING_EN
            pending_d = 1'b0;
`endif
            if (take_pending) begin
              state_d = S_ON;
              cnt_d   = ON_CNT;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else if (beat_1ms_i && cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_led_activity_stretcher.sv
// Randomized and directed checks of led_activity_stretcher against a beat-counting blink model.
module tb_led_activity_stretcher;

  localparam int ON  = 3;
  localparam int OFF = 2;
`ifdef LED_ACT_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic beat_1ms_i = 1'b0;
  logic event_i = 1'b0;
  logic enable_i = 1'b1;
  logic led_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a blink is "active" and counts beats since it started; LED is lit for
  // the first ON beats, then dark until ON+OFF beats have elapsed.
  bit m_act  = 1'b0;
  bit m_pend = 1'b0;
  int m_n    = 0;

  led_activity_stretcher #(.ON_MS(ON), .OFF_MS(OFF), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .beat_1ms_i(beat_1ms_i),
    .event_i(event_i), .enable_i(enable_i), .led_o(led_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_led();
    return m_act && (m_n < ON);
  endfunction

  task automatic model_reset();
    m_act = 0; m_pend = 0; m_n = 0;
  endtask

  task automatic model_edge(input bit ev, input bit bt, input bit en);
    if (!en) begin
      m_act = 0; m_pend = 0;
    end else if (!m_act) begin
      if (ev) begin m_act = 1; m_n = 0; m_pend = 0; end
    end else begin
      if (PEND_EN && ev) m_pend = 1;
      if (bt) begin
        m_n++;
        if (m_n == ON + OFF) begin
          if (m_pend) begin m_n = 0; m_pend = 0; end
          else m_act = 0;
        end
      end
    end
  endtask

  task automatic clk_step(input bit ev, input bit bt, input bit en);
    event_i = ev; beat_1ms_i = bt; enable_i = en;
    @(posedge clk_i);
    model_edge(ev, bt, en);
    #1;
  endtask

  task automatic flush();
    clk_step(0, 0, 0);
    clk_step(0, 0, 1);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: led=%b busy=%b want 0 0", led_o, busy_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) clk_step(0, (i == 2), 1);
    n_checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: led=%b busy=%b want 0 0", led_o, busy_o);
    end
  endtask

  task automatic test_single_blink();
    clk_step(1, 0, 1);
    n_checks++;
    if (led_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: led=%b busy=%b want 1 1", led_o, busy_o);
    end
    for (int i = 0; i < 70; i++) begin
      clk_step(0, (i % 10 == 9), 1);
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL single_cycle%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
    n_checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_end: led=%b busy=%b want 0 0", led_o, busy_o);
    end
  endtask

  task automatic test_event_with_beat();
    int lit_beats = 0;
    clk_step(1, 1, 1);
    for (int i = 0; i < 60; i++) begin
      bit bt = (i % 10 == 9);
      if (bt && led_o === 1'b1) lit_beats++;
      clk_step(0, bt, 1);
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL evbeat_cycle%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
    n_checks++;
    if (lit_beats != ON) begin
      n_fail++; $display("FAIL evbeat_lit_beats: got %0d want %0d", lit_beats, ON);
    end
  endtask

  task automatic test_second_event();
    int rises = 0;
    logic prev = 1'b0;
    clk_step(1, 0, 1);
    prev = led_o; rises = 1;
    for (int i = 0; i < 120; i++) begin
      clk_step((i == 14), (i % 10 == 9), 1);
      if (led_o === 1'b1 && prev === 1'b0) rises++;
      prev = led_o;
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL second_cycle%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
    n_checks++;
    if (rises != (PEND_EN ? 2 : 1)) begin
      n_fail++; $display("FAIL second_blinks: got %0d want %0d", rises, PEND_EN ? 2 : 1);
    end
  endtask

  task automatic test_disable();
    clk_step(1, 0, 1);
    for (int i = 0; i < 12; i++) clk_step(0, (i % 10 == 9), 1);
    clk_step(0, 0, 0);
    n_checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL disable_force: led=%b busy=%b want 0 0", led_o, busy_o);
    end
    for (int i = 0; i < 8; i++) begin
      clk_step((i == 2), (i == 4), 0);
      n_checks++;
      if (led_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++; $display("FAIL disable_ignore%0d: led=%b busy=%b want 0 0", i, led_o, busy_o);
      end
    end
    clk_step(0, 0, 1);
  endtask

  task automatic test_async_reset();
    clk_step(1, 0, 1);
    for (int i = 0; i < 12; i++) clk_step(0, (i % 10 == 9), 1);
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (led_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_drop: led=%b busy=%b want 0 0", led_o, busy_o);
    end
    #1 rst_i = 1'b0;
    model_reset();
    clk_step(0, 0, 1);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_idle: busy=%b want 0", busy_o);
    end
    clk_step(1, 0, 1);
    for (int i = 0; i < 60; i++) begin
      clk_step(0, (i % 10 == 9), 1);
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL async_reblink%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
  endtask

  task automatic test_sustained();
    int busy_low = 0;
    for (int i = 0; i < 200; i++) begin
      clk_step(1, (i % 10 == 9), 1);
      if (busy_o === 1'b0) busy_low++;
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL sustained_cycle%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
    n_checks++;
    if (PEND_EN ? (busy_low != 0) : (busy_low == 0)) begin
      n_fail++; $display("FAIL sustained_idle_gap: busy low %0d cycles, pending_en=%0d", busy_low, PEND_EN);
    end
    flush();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      clk_step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 59) != 0);
      n_checks++;
      if (led_o !== m_led() || busy_o !== m_act) begin
        n_fail++; $display("FAIL random_cycle%0d: led=%b busy=%b want %b %b", i, led_o, busy_o, m_led(), m_act);
      end
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_single_blink();
    flush();
    test_event_with_beat();
    flush();
    test_second_event();
    flush();
    test_disable();
    test_async_reset();
    flush();
    test_sustained();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
